// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring bus consumers.
package ring_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } ring_state_e;

  // Rotate the low w bits of x by one position; dir=1 moves bit i to bit i+1.
  function automatic logic [MAX_W-1:0] rot(input logic [MAX_W-1:0] x,
                                           input int unsigned w,
                                           input logic dir);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        if (dir) r[(i + 1) % w]     = x[i];
        else     r[(i + w - 1) % w] = x[i];
      end
    end
    return r;
  endfunction

  function automatic logic onehot_legal(input logic [MAX_W-1:0] x);
    return ($countones(x) == 1);
  endfunction

endpackage

// File: rtl/ring_monitor_onehot_decoder.sv
// Combinational one-hot to binary decoder with a legality flag.
module onehot_decoder import ring_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         ring,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     legal
);

  localparam int IDX_W = $clog2(WIDTH);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring[i]) idx = idx | IDX_W'(i);
    end
    legal = onehot_legal(MAX_W'(ring));
  end

endmodule

// File: rtl/ring_monitor.sv
// Ring bus monitor: one-hot decode, rotation tracking, lock detection and error counting.
module ring_monitor import ring_pkg::*; #(
  parameter int WIDTH      = 4,
  parameter int SHIFT_LEFT = 1,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Sample_en,
  input  logic [WIDTH-1:0]         Ring_in,
  output logic [$clog2(WIDTH)-1:0] Index_out,
  output logic                     Valid_out,
  output logic                     Locked,
  output logic                     Error_pulse,
  output logic [ERR_CNT_W-1:0]     Error_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CW    = $clog2(LOCK_COUNT + 1);

  ring_state_e          state_q, state_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [CW-1:0]        match_q, match_d, match_inc;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_legal;
  logic [WIDTH-1:0]     rot_in;

  onehot_decoder #(.WIDTH(WIDTH)) u_dec (
    .ring  (Ring_in),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  always_comb begin
    rot_in    = WIDTH'(rot(MAX_W'(Ring_in), WIDTH, SHIFT_LEFT != 0));
    match_inc = match_q + 1'b1;

    state_d     = state_q;
    expected_d  = expected_q;
    match_d     = match_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    err_pulse_d = 1'b0;

    if (Sample_en) begin
      valid_d = dec_legal;
      if (dec_legal) idx_d = dec_idx;

      unique case (state_q)
        S_IDLE: begin
          if (dec_legal) begin
            expected_d = rot_in;
            match_d    = '0;
            state_d    = S_TRACK;
          end
        end
        S_TRACK: begin
          if (!dec_legal) begin
            state_d = S_IDLE;
          end else if (Ring_in == expected_q) begin
            expected_d = rot_in;
            match_d    = match_inc;
            if (match_inc == CW'(LOCK_COUNT)) state_d = S_LOCKED;
          end else begin
            expected_d = rot_in;
            match_d    = '0;
          end
        end
        S_LOCKED: begin
          // expected_q is always one-hot here, so equality implies legality
          if (Ring_in == expected_q) begin
            expected_d = rot_in;
          end else if (dec_legal) begin
            err_pulse_d = 1'b1;
            expected_d  = rot_in;
            match_d     = '0;
            state_d     = S_TRACK;
          end else begin
            err_pulse_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    locked_d  = (state_d == S_LOCKED);
    err_cnt_d = err_cnt_q;
    if (err_pulse_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      expected_q  <= '0;
      match_q     <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_q     <= match_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign Index_out   = idx_q;
  assign Valid_out   = valid_q;
  assign Locked      = locked_q;
  assign Error_pulse = err_pulse_q;
  assign Error_count = err_cnt_q;

endmodule
